line_buffer_scheduler: RTL and testbench
========================================

// Module: line_buffer_scheduler
// PURPOSE
//  Row-rotation controller for the (KERNEL_SIZE+1)-BRAM line buffer in the convolution path.
//  Tracks the raster stream (hcount/vcount/valid) and drives the one-hot BRAM write enables.
//  Publishes the read-row order (oldest row first) and gates window-valid until KERNEL_SIZE full rows are stored.
//  Flags raster sequencing errors. Sits between the camera/pixel source and the line buffer datapath.
// PARAMETERS
//  HRES         1280  pixels per line
//  VRES         720   lines per frame
//  KERNEL_SIZE  3     kernel rows; number of row BRAMs N = KERNEL_SIZE+1
//  (derived) HWIDTH=$clog2(HRES), VWIDTH=$clog2(VRES), IDXW=$clog2(KERNEL_SIZE+1)
// PORTS
//  clk_in            in   1                 system clock
//  rst_in            in   1                 reset, asynchronous, active-high
//  hcount_in         in   HWIDTH            hcount of incoming pixel
//  vcount_in         in   VWIDTH            vcount of incoming pixel
//  data_valid_in     in   1                 incoming pixel valid
//  wr_en_out         out  N                 one-hot BRAM write enable (combinational, same cycle as pixel)
//  wr_idx_out        out  IDXW              index of the row BRAM currently being written (registered)
//  rd_idx_out        out  KERNEL_SIZE*IDXW  slot k = BRAM index feeding kernel row k, k=0 oldest
//  rows_filled_out   out  $clog2(KERNEL_SIZE+1)  complete rows stored this frame, saturates at KERNEL_SIZE
//  window_valid_out  out  1                 window for previous-cycle pixel is valid (1-cycle latency)
//  line_end_out      out  1                 1-cycle pulse, cycle after last pixel of a line accepted
//  frame_start_out   out  1                 1-cycle pulse, cycle after pixel (0,0) accepted
//  seq_err_out       out  1                 sticky raster error; cleared by reset or next frame start
//  state_out         out  2                 0=IDLE 1=FILL 2=STREAM
// BEHAVIOUR
//  Reset (async assert, sync-to-clk release): state IDLE, wr_idx 0, rows_filled 0, all outputs 0;
//   rd_idx_out = {3,2,1} pattern for wr_idx 0 (formula below always holds).
//  fs  = data_valid_in && hcount_in==0 && vcount_in==0 (frame start, any state).
//  le  = data_valid_in && hcount_in==HRES-1 (line end).
//  wr_en_out: fs -> 1<<0; else state!=IDLE && data_valid_in -> 1<<wr_idx; else 0.
//  rd_idx_out slot k = (wr_idx+1+k) mod N, recomputed combinationally from wr_idx.
//  IDLE: ignore everything except fs. On fs -> FILL, wr_idx<=0, rows_filled<=0, seq_err<=0.
//  FILL: on le -> wr_idx<=(wr_idx+1) mod N, rows_filled<=rows_filled+1;
//   if new rows_filled==KERNEL_SIZE -> STREAM.
//  STREAM: on le -> wr_idx<=(wr_idx+1) mod N, rows_filled held at KERNEL_SIZE;
//   if vcount_in==VRES-1 -> IDLE (frame complete).
//  window_valid_out <= data_valid_in && state==STREAM (registered; pixel cycle +1).
//  fs in FILL/STREAM restarts frame exactly as from IDLE (mid-frame resync); fs beats le.
//  Expected hcount tracked: after fs/le expect 0 / next line, else last+1.
//   Valid pixel with hcount_in != expected while not IDLE -> seq_err_out<=1 (sticky).
//   vcount_in at le not matching line count since fs -> seq_err_out<=1.
//   Errors do not alter rotation; hcount-based le still rotates.
//  data_valid_in low: no state change, no rotation, wr_en_out 0; gaps of any length allowed.
//  line_end_out/frame_start_out registered from le/fs, 1 cycle each.
//  Reset asserted mid-line: all state cleared immediately; next write only after fs.
// TESTING (sim params HRES=8, VRES=6, KERNEL_SIZE=3, N=4)
//  Reset then pixels with vcount=2 (no fs) -> wr_en_out=0, state_out=IDLE throughout.
//  Full frame, continuous valid -> wr_idx 0,1,2,3,0,1 per line; state FILL->STREAM after
//   line 2 end; window_valid_out high for 24 cycles (lines 3-5); IDLE after (7,5).
//  In STREAM with wr_idx=1 -> rd_idx_out slots {2,3,0} (k=0..2), wr_en_out=4'b0010.
//  Valid gapped every other cycle -> identical rotation; window_valid_out only after valid pixels.
//  Skip hcount 3->5 in line 1 -> seq_err_out=1 next cycle, stays 1; next fs clears to 0.
//  fs injected at line 4 hcount 0 -> wr_en_out=4'b0001 that cycle, rows_filled 0, state FILL,
//   frame_start_out pulse; async reset mid-line -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/line_buffer_scheduler.sv
// Row-rotation controller for the (KERNEL_SIZE+1)-BRAM line buffer.
// Tracks the raster stream, rotates write rows, publishes read order.
module line_buffer_scheduler #(
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int KERNEL_SIZE = 3,
  localparam int N      = KERNEL_SIZE + 1,
  localparam int HWIDTH = $clog2(HRES),
  localparam int VWIDTH = $clog2(VRES),
  localparam int IDXW   = $clog2(KERNEL_SIZE + 1),
  localparam int RFW    = $clog2(KERNEL_SIZE + 1)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [HWIDTH-1:0]          hcount_in,
  input  logic [VWIDTH-1:0]          vcount_in,
  input  logic                       data_valid_in,
  output logic [N-1:0]               wr_en_out,
  output logic [IDXW-1:0]            wr_idx_out,
  output logic [KERNEL_SIZE*IDXW-1:0] rd_idx_out,
  output logic [RFW-1:0]             rows_filled_out,
  output logic                       window_valid_out,
  output logic                       line_end_out,
  output logic                       frame_start_out,
  output logic                       seq_err_out,
  output logic [1:0]                 state_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IDXW-1:0]   wr_idx, wr_idx_n;
  logic [IDXW-1:0]   wr_idx_inc;
  logic [RFW-1:0]    rows, rows_n;
  logic              err, err_n;
  logic [HWIDTH-1:0] exp_h, exp_h_n;
  logic [VWIDTH-1:0] line_cnt, line_cnt_n;
  logic              fs, le;
  logic [IDXW:0]     rd_sum;

  assign fs = data_valid_in
           && (hcount_in == '0)
           && (vcount_in == '0);
  assign le = data_valid_in
           && (hcount_in == HWIDTH'(HRES - 1));

  assign wr_idx_inc = (wr_idx == IDXW'(N - 1))
                    ? '0
                    : wr_idx + IDXW'(1);

  // One-hot write enable for the row BRAM receiving this pixel
  always_comb begin
    wr_en_out = '0;
    if (fs)
      wr_en_out[0] = 1'b1;
    else if (state != IDLE && data_valid_in)
      wr_en_out[wr_idx] = 1'b1;
  end

  // Read order: oldest stored row first, newest row last
  always_comb begin
    rd_idx_out = '0;
    rd_sum     = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      rd_sum = {1'b0, wr_idx} + (IDXW+1)'(k + 1);
      if (rd_sum >= (IDXW+1)'(N))
        rd_sum = rd_sum - (IDXW+1)'(N);
      rd_idx_out[k*IDXW +: IDXW] = rd_sum[IDXW-1:0];
    end
  end

  // Next-state: frame restart, row rotation, raster sequence checks
  always_comb begin
    state_n    = state;
    wr_idx_n   = wr_idx;
    rows_n     = rows;
    err_n      = err;
    exp_h_n    = exp_h;
    line_cnt_n = line_cnt;
    if (fs) begin
      state_n    = FILL;
      wr_idx_n   = '0;
      rows_n     = '0;
      err_n      = 1'b0;
      exp_h_n    = HWIDTH'(1);
      line_cnt_n = '0;
    end else if (data_valid_in && state != IDLE) begin
      if (hcount_in != exp_h)
        err_n = 1'b1;
      exp_h_n = hcount_in + HWIDTH'(1);
      if (le) begin
        if (vcount_in != line_cnt)
          err_n = 1'b1;
        exp_h_n    = '0;
        line_cnt_n = line_cnt + VWIDTH'(1);
        wr_idx_n   = wr_idx_inc;
        case (state)
          FILL: begin
            rows_n = rows + RFW'(1);
            if (rows + RFW'(1) == RFW'(KERNEL_SIZE))
              state_n = STREAM;
          end
          STREAM: begin
            rows_n = RFW'(KERNEL_SIZE);
            if (vcount_in == VWIDTH'(VRES - 1))
              state_n = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Control state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      wr_idx   <= '0;
      rows     <= '0;
      err      <= 1'b0;
      exp_h    <= '0;
      line_cnt <= '0;
    end else begin
      state    <= state_n;
      wr_idx   <= wr_idx_n;
      rows     <= rows_n;
      err      <= err_n;
      exp_h    <= exp_h_n;
      line_cnt <= line_cnt_n;
    end
  end

  // Registered pulses and window qualifier, one cycle after the pixel
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      window_valid_out <= 1'b0;
      line_end_out     <= 1'b0;
      frame_start_out  <= 1'b0;
    end else begin
      window_valid_out <= data_valid_in && (state == STREAM);
      line_end_out     <= le;
      frame_start_out  <= fs;
    end
  end

  assign wr_idx_out      = wr_idx;
  assign rows_filled_out = rows;
  assign seq_err_out     = err;
  assign state_out       = state;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Randomized bench for line_buffer_scheduler against a
// raster-level reference model (HRES=8, VRES=6, KERNEL_SIZE=3).
module tb_line_buffer_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] hcount;
  logic [2:0] vcount;
  logic       data_valid;
  logic [3:0] wr_en;
  logic [1:0] wr_idx;
  logic [5:0] rd_idx;
  logic [1:0] rows_filled;
  logic       window_valid;
  logic       line_end;
  logic       frame_start;
  logic       seq_err;
  logic [1:0] state;

  line_buffer_scheduler #(
    .HRES(8), .VRES(6), .KERNEL_SIZE(3)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .data_valid_in   (data_valid),
    .wr_en_out       (wr_en),
    .wr_idx_out      (wr_idx),
    .rd_idx_out      (rd_idx),
    .rows_filled_out (rows_filled),
    .window_valid_out(window_valid),
    .line_end_out    (line_end),
    .frame_start_out (frame_start),
    .seq_err_out     (seq_err),
    .state_out       (state)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int wv_seen;

  // Reference model: frame activity and count of lines ended since fs
  int active, lines, m_err, exp_h;
  int m_wv, m_le, m_fs;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    active = 0; lines = 0; m_err = 0; exp_h = 0;
    m_wv = 0; m_le = 0; m_fs = 0;
  endtask

  function automatic int m_state();
    if (!active) return 0;
    return (lines < 3) ? 1 : 2;
  endfunction

  function automatic int m_rd(input int w);
    int r = 0;
    for (int k = 0; k < 3; k++)
      r |= ((w + 1 + k) % 4) << (2 * k);
    return r;
  endfunction

  // One clock cycle: drive, compare, clock, advance model
  task automatic cyc(input bit v, input int h, input int vc);
    bit fs, le;
    int w, st, we;
    data_valid = v;
    hcount = h[2:0];
    vcount = vc[2:0];
    #1;
    fs = v && h == 0 && vc == 0;
    le = v && h == 7;
    w  = lines % 4;
    st = m_state();
    we = fs ? 1 : ((active != 0 && v) ? (1 << w) : 0);
    chk("wr_en", wr_en, we);
    chk("wr_idx", wr_idx, w);
    chk("rd_idx", rd_idx, m_rd(w));
    chk("rows_filled", rows_filled, lines < 3 ? lines : 3);
    chk("state", state, st);
    chk("window_valid", window_valid, m_wv);
    chk("line_end", line_end, m_le);
    chk("frame_start", frame_start, m_fs);
    chk("seq_err", seq_err, m_err);
    if (window_valid) wv_seen++;
    @(posedge clk);
    m_wv = (v && st == 2) ? 1 : 0;
    m_le = le;
    m_fs = fs;
    if (fs) begin
      active = 1; lines = 0; m_err = 0; exp_h = 1;
    end else if (v && active != 0) begin
      if (h != exp_h) m_err = 1;
      exp_h = h + 1;
      if (le) begin
        if (vc != lines) m_err = 1;
        exp_h = 0;
        if (st == 2 && vc == 5) active = 0;
        lines++;
      end
    end
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, $urandom_range(7), $urandom_range(5));
  endtask

  // gap: 0 none, 1 alternate cycles, 2 random 0..3
  task automatic line(input int y, input int x0,
                      input int gap, input int skip);
    for (int x = x0; x < 8; x++) begin
      if (x == skip) continue;
      if (gap == 1) idle_cyc();
      if (gap == 2) repeat ($urandom_range(3)) idle_cyc();
      cyc(1'b1, x, y);
    end
  endtask

  task automatic frame(input int gap, input int skip_line,
                       input int skip_x);
    for (int y = 0; y < 6; y++)
      line(y, 0, gap, y == skip_line ? skip_x : -1);
  endtask

  initial begin
    rst = 1'b1;
    data_valid = 1'b0;
    hcount = '0;
    vcount = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rd_idx", rd_idx, 57);
    chk("reset_state", state, 0);

    // Pixels without a frame start are ignored
    for (int x = 0; x < 8; x++) cyc(1'b1, x, 2);
    chk("nofs_state", state, 0);

    // Clean continuous frame
    wv_seen = 0;
    for (int y = 0; y < 6; y++) begin
      line(y, 0, 0, -1);
      if (y == 2) chk("fill_to_stream", state, 2);
      if (y == 4) begin
        chk("stream_wr_idx", wr_idx, 1);
        chk("stream_rd_idx", rd_idx, 14);
        data_valid = 1'b1; hcount = 3'd0; vcount = 3'd5;
        #1 chk("stream_wr_en", wr_en, 2);
      end
    end
    idle_cyc();
    chk("wv_count_cont", wv_seen, 24);
    chk("idle_after_frame", state, 0);

    // Alternate-cycle gaps give the same rotation
    wv_seen = 0;
    frame(1, -1, -1);
    idle_cyc();
    chk("wv_count_gapped", wv_seen, 24);

    // hcount skip 3->5 in line 1: sticky error, cleared by next fs
    frame(0, 1, 4);
    chk("seq_err_sticky", seq_err, 1);
    idle_cyc();
    cyc(1'b1, 0, 0);
    chk("seq_err_cleared", seq_err, 0);
    line(0, 1, 0, -1);
    for (int y = 1; y < 6; y++) line(y, 0, 0, -1);

    // Mid-frame resync: fs arrives where line 4 should start
    for (int y = 0; y < 4; y++) line(y, 0, 0, -1);
    cyc(1'b1, 0, 0);
    chk("inj_state", state, 1);
    chk("inj_rows", rows_filled, 0);
    chk("inj_fs_pulse", frame_start, 1);
    line(0, 1, 0, -1);
    for (int y = 1; y < 6; y++) line(y, 0, 0, -1);

    // Async reset mid-line while streaming
    for (int y = 0; y < 3; y++) line(y, 0, 0, -1);
    for (int x = 0; x < 4; x++) cyc(1'b1, x, 3);
    data_valid = 1'b1; hcount = 3'd4; vcount = 3'd3;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_wr_idx", wr_idx, 0);
    chk("arst_rows", rows_filled, 0);
    chk("arst_wv", window_valid, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_rd_idx", rd_idx, 57);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int x = 5; x < 8; x++) cyc(1'b1, x, 3);

    // Random frames with random gaps and occasional skips
    for (int f = 0; f < 4; f++) begin
      if ($urandom_range(2) == 0)
        frame(2, $urandom_range(5), $urandom_range(1, 7));
      else
        frame(2, -1, -1);
    end

    // Unconstrained raster noise
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(3) != 0, $urandom_range(7),
          $urandom_range(5));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
